// File: rtl/button_pkg.sv
// Shared types for the button event classifier: event codes and FSM states.
package button_pkg;

    typedef enum logic [1:0] {
        EV_SHORT  = 2'd0,
        EV_DOUBLE = 2'd1,
        EV_LONG   = 2'd2,
        EV_REPEAT = 2'd3
    } ev_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS1   = 3'd1,
        ST_HOLD     = 3'd2,
        ST_WAIT_DC  = 3'd3,
        ST_PRESS2   = 3'd4,
        ST_WAIT_REL = 3'd5
    } btn_state_t;

    // Largest of the three timing parameters; sizes the shared counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registered one-cycle rise/fall pulses from the debounced button level.
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    logic btn_prev_q;
    logic rise_q;
    logic fall_q;

    // Track the previous level; during reset capture the live level so a
    // button held across reset does not look like a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q <= btn_level;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            btn_prev_q <= btn_level;
            rise_q     <= btn_level & ~btn_prev_q;
            fall_q     <= ~btn_level & btn_prev_q;
        end
    end

    assign btn_rise = rise_q;
    assign btn_fall = fall_q;

endmodule

// File: rtl/button_event_gen.sv
// Classifies button presses into SHORT/DOUBLE/LONG/REPEAT events and
// presents them through a single-entry valid/ready slot.
module button_event_gen
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int DCLICK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_level,
    output logic       btn_rise,
    output logic       btn_fall,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    input  logic       ev_ready,
    output logic       ev_overflow
);

    localparam int CNT_W = $clog2(max3(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_T = CNT_W'(DCLICK_CYCLES - 1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             emit;
    ev_code_t         emit_code;
    logic             ev_valid_q, ev_valid_d;
    ev_code_t         ev_code_q, ev_code_d;
    logic             ev_overflow_q, ev_overflow_d;
    logic             accept;

    btn_edge_detect u_edge (
        .clk       (clk),
        .rst       (rst),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    // Next state and event emission; edges win over counter terminals,
    // and any state change restarts the shared counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        emit      = 1'b0;
        emit_code = EV_SHORT;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_rise) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (btn_fall) begin
                    state_d = ST_WAIT_DC;
                end else if (cnt_q == LONG_T) begin
                    emit      = 1'b1;
                    emit_code = EV_LONG;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (btn_fall) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == REPEAT_T) begin
                    emit      = 1'b1;
                    emit_code = EV_REPEAT;
                    cnt_d     = '0;
                end
            end
            ST_WAIT_DC: begin
                if (btn_rise) begin
                    state_d = ST_PRESS2;
                end else if (cnt_q == DCLICK_T) begin
                    emit      = 1'b1;
                    emit_code = EV_SHORT;
                    state_d   = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (btn_fall) begin
                    emit      = 1'b1;
                    emit_code = EV_DOUBLE;
                    state_d   = ST_IDLE;
                end else if (cnt_q == LONG_T) begin
                    emit      = 1'b1;
                    emit_code = EV_DOUBLE;
                    state_d   = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (btn_fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Event slot: load when empty or drained this cycle, otherwise drop
    // the new event and flag overflow.
    always_comb begin
        accept        = ev_valid_q & ev_ready;
        ev_valid_d    = ev_valid_q;
        ev_code_d     = ev_code_q;
        ev_overflow_d = ev_overflow_q;
        if (emit) begin
            if (!ev_valid_q || accept) begin
                ev_valid_d = 1'b1;
                ev_code_d  = emit_code;
            end else begin
                ev_overflow_d = 1'b1;
            end
        end else if (accept) begin
            ev_valid_d = 1'b0;
        end
    end

    // State, counter and slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ev_valid_q    <= 1'b0;
            ev_code_q     <= EV_SHORT;
            ev_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ev_valid_q    <= ev_valid_d;
            ev_code_q     <= ev_code_d;
            ev_overflow_q <= ev_overflow_d;
        end
    end

    assign ev_valid    = ev_valid_q;
    assign ev_code     = ev_code_q;
    assign ev_overflow = ev_overflow_q;

endmodule
